bp_be_issue_queue_nw: RTL

//  Parametrised N-lane successor to the dual-issue BE instruction queue.

---
 rtl/bp_be_pkg.sv | 29 ++
 rtl/bp_be_queue_ptr.sv | 23 ++
 rtl/bsg_mem_multiport.sv | 29 ++
 rtl/bp_be_issue_queue_nw.sv | 121 ++++++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
// Shared types and helpers for the BE issue queue: default sizing,
// pointer-width helpers and a small popcount for lane masks.
package bp_be_pkg;

    localparam int lanes_gp     = 2;
    localparam int els_gp       = 16;
    localparam int width_gp     = 64;
    localparam int max_lanes_gp = 4;

    function automatic int ptr_w_f(input int els);
        return $clog2(els);
    endfunction

    function automatic int cnt_w_f(input int lanes);
        return $clog2(lanes + 1);
    endfunction

    function automatic int occ_w_f(input int els);
        return $clog2(els) + 1;
    endfunction

    function automatic logic [2:0] popcount_f(input logic [max_lanes_gp-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < max_lanes_gp; i++) n = n + {2'b00, v[i]};
        return n;
    endfunction

endpackage

// File: rtl/bp_be_queue_ptr.sv
// Wrapping queue pointer: either loads a new value or advances by a
// variable amount; n_o exposes the next value combinationally.
module bp_be_queue_ptr #(
    parameter int width_p = 4,
    parameter int add_w_p = 3
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               load_v_i,
    input  logic [width_p-1:0] load_val_i,
    input  logic [add_w_p-1:0] add_i,
    output logic [width_p-1:0] ptr_o,
    output logic [width_p-1:0] n_o
);

    assign n_o = load_v_i ? load_val_i : ptr_o + width_p'(add_i);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) ptr_o <= '0;
        else            ptr_o <= n_o;
    end

endmodule

// File: rtl/bsg_mem_multiport.sv
// Multi-ported register-file store: synchronous writes, combinational reads.
// Callers guarantee write addresses never collide within a cycle.
module bsg_mem_multiport #(
    parameter  int width_p       = 64,
    parameter  int els_p         = 16,
    parameter  int read_ports_p  = 2,
    parameter  int write_ports_p = 2,
    localparam int addr_w        = $clog2(els_p)
) (
    input  logic                                   clk_i,
    input  logic [write_ports_p-1:0]               w_v_i,
    input  logic [write_ports_p-1:0][addr_w-1:0]   w_addr_i,
    input  logic [write_ports_p-1:0][width_p-1:0]  w_data_i,
    input  logic [read_ports_p-1:0][addr_w-1:0]    r_addr_i,
    output logic [read_ports_p-1:0][width_p-1:0]   r_data_o
);

    logic [width_p-1:0] mem [els_p];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < write_ports_p; i++)
            if (w_v_i[i]) mem[w_addr_i[i]] <= w_data_i[i];
    end

    for (genvar k = 0; k < read_ports_p; k++) begin : g_rd
        assign r_data_o[k] = mem[r_addr_i[k]];
    end

endmodule

// File: rtl/bp_be_issue_queue_nw.sv
// N-lane BE issue queue: circular store with write / read / checkpoint
// pointers, in-order multi-lane dequeue, roll-back to checkpoint and clear.
module bp_be_issue_queue_nw
    import bp_be_pkg::*;
#(
    parameter  int lanes_p = lanes_gp,
    parameter  int els_p   = els_gp,
    parameter  int width_p = width_gp,
    localparam int ptr_w   = ptr_w_f(els_p),
    localparam int cnt_w   = cnt_w_f(lanes_p),
    localparam int occ_w   = occ_w_f(els_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       clr_v_i,
    input  logic                       roll_v_i,
    input  logic [cnt_w-1:0]           commit_cnt_i,
    input  logic [lanes_p-1:0]         enq_v_i,
    input  logic [lanes_p*width_p-1:0] enq_data_i,
    output logic                       enq_ready_o,
    output logic [lanes_p-1:0]         deq_v_o,
    output logic [lanes_p*width_p-1:0] deq_data_o,
    input  logic [lanes_p-1:0]         deq_yumi_i,
    output logic [occ_w-1:0]           occupancy_o
);

    localparam int pw = ptr_w + 1;

    logic [pw-1:0]       wptr, rptr, cptr, wptr_n, rptr_n, cptr_n;
    logic [occ_w-1:0]    occupancy, unread;
    logic [lanes_p-1:0]  enq_fire;
    logic [max_lanes_gp-1:0] enq_pad, yumi_pad;
    logic [2:0]          enq_cnt, yumi_cnt;

    logic [lanes_p-1:0][width_p-1:0] enq_data, rd_data;
    logic [lanes_p-1:0][ptr_w-1:0]   wr_addr, rd_addr;

    assign occupancy   = wptr - cptr;
    assign unread      = wptr - rptr;
    assign occupancy_o = occupancy;

    // Full is judged against the checkpoint so uncommitted entries survive a roll.
    assign enq_ready_o = !clr_v_i && (occupancy <= occ_w'(els_p - lanes_p));
    assign enq_fire    = enq_v_i & {lanes_p{enq_ready_o}};

    assign enq_pad  = max_lanes_gp'(enq_fire);
    assign yumi_pad = max_lanes_gp'(deq_yumi_i);
    assign enq_cnt  = popcount_f(enq_pad);
    assign yumi_cnt = popcount_f(yumi_pad);

    bp_be_queue_ptr #(.width_p(pw), .add_w_p(3)) c_ptr (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .load_v_i   (1'b0),
        .load_val_i ('0),
        .add_i      (3'(commit_cnt_i)),
        .ptr_o      (cptr),
        .n_o        (cptr_n)
    );

    bp_be_queue_ptr #(.width_p(pw), .add_w_p(3)) r_ptr (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .load_v_i   (roll_v_i),
        .load_val_i (cptr_n),
        .add_i      (yumi_cnt),
        .ptr_o      (rptr),
        .n_o        (rptr_n)
    );

    bp_be_queue_ptr #(.width_p(pw), .add_w_p(3)) w_ptr (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .load_v_i   (clr_v_i),
        .load_val_i (rptr_n),
        .add_i      (enq_cnt),
        .ptr_o      (wptr),
        .n_o        (wptr_n)
    );

    assign enq_data = enq_data_i;

    for (genvar k = 0; k < lanes_p; k++) begin : g_lane
        assign wr_addr[k] = wptr[ptr_w-1:0] + ptr_w'(k);
        assign rd_addr[k] = rptr[ptr_w-1:0] + ptr_w'(k);
        assign deq_v_o[k] = !roll_v_i && (unread > occ_w'(k));
        assign deq_data_o[k*width_p +: width_p] = deq_v_o[k] ? rd_data[k] : '0;
    end

    bsg_mem_multiport #(
        .width_p       (width_p),
        .els_p         (els_p),
        .read_ports_p  (lanes_p),
        .write_ports_p (lanes_p)
    ) store (
        .clk_i    (clk_i),
        .w_v_i    (enq_fire),
        .w_addr_i (wr_addr),
        .w_data_i (enq_data),
        .r_addr_i (rd_addr),
        .r_data_o (rd_data)
    );

    logic [lanes_p-1:0] enq_inc, yumi_inc;
    assign enq_inc  = enq_v_i + lanes_p'(1);
    assign yumi_inc = deq_yumi_i + lanes_p'(1);

    a_enq_thermo: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (enq_v_i & enq_inc) == '0);
    a_yumi_thermo: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (deq_yumi_i & yumi_inc) == '0);
    a_yumi_subset: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        roll_v_i || ((deq_yumi_i & ~deq_v_o) == '0));
    a_commit: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        occ_w'(commit_cnt_i) <= occ_w'(rptr - cptr));
    a_order: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        occ_w'(rptr - cptr) <= occ_w'(wptr - cptr));
    a_occ: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (occupancy <= occ_w'(els_p)) && (occ_w'(wptr_n - cptr_n) <= occ_w'(els_p)));

endmodule
